acc_tile_beatizer: RTL and testbench
====================================

# acc_tile_beatizer

Double-buffered tile-to-beat converter that sits directly upstream of the QDQ controller's dequantize input (`dq_s_*` / `dq_tfirst_i`). It accepts one complete MAT_SIZE×MAT_SIZE accumulator tile per handshake from the GEMM core. It re-emits the tile as BEATS = ceil(MAT_SIZE²/LANES_NUM) lane-wide beats, with first-beat and last-beat markers. Two tile slots let the core deliver the next tile while the current one drains, so the dequantizer sees back-to-back tiles with no bubbles.

## Interface
- MAT_SIZE, 16, tile edge; ELEMS = MAT_SIZE² elements per tile.
- FP_DATA_W, 32, bits per accumulator element.
- LANES_NUM, 16, elements per output beat; BEATS = ceil(ELEMS/LANES_NUM).
- clk  in  1  clock, all logic on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush_i  in  1  synchronous clear of buffered tiles.
- s_valid_i  in  1  input tile valid.
- s_ready_o  out  1  a free slot exists.
- s_data_i  in  ELEMS*FP_DATA_W  tile; element e = row*MAT_SIZE+col at bits [e*FP_DATA_W +: FP_DATA_W].
- m_valid_o  out  1  output beat valid.
- m_ready_i  in  1  downstream accepts beat.
- m_data_o  out  LANES_NUM*FP_DATA_W  beat; lane l at [l*FP_DATA_W +: FP_DATA_W].
- m_tfirst_o  out  1  beat 0 of a tile.
- m_tlast_o  out  1  beat BEATS-1 of a tile.
- tile_cnt_o  out  16  number of tiles fully emitted.

## Operation
- State:
  - Two slots of ELEMS*FP_DATA_W bits.
  - wr_ptr and rd_ptr, 1 bit each.
  - occ, 0..2, count of filled slots.
  - beat_idx, clog2(BEATS)+1 bits.
  - tile_cnt, 16 bits.
- Input accept:
  - s_ready_o = (occ != 2), driven purely from registered state with no dependence on s_valid_i.
  - On s_valid_i & s_ready_o: write s_data_i into slot[wr_ptr] and toggle wr_ptr.
- Output:
  - m_valid_o = (occ != 0).
  - Beat b, lane l carries element b*LANES_NUM+l of slot[rd_ptr].
  - Lanes whose element index is ≥ ELEMS are driven 0 (last-beat padding).
- Output advance, on m_valid_o & m_ready_i:
  - If beat_idx == BEATS-1: clear beat_idx to 0, toggle rd_ptr, increment tile_cnt (wraps 65535→0).
  - Otherwise: increment beat_idx.
- Framing:
  - m_tfirst_o = m_valid_o & (beat_idx == 0).
  - m_tlast_o = m_valid_o & (beat_idx == BEATS-1).
  - When BEATS == 1, both markers assert on the same beat.
- occ update:
  - +1 on accept only.
  - −1 on final-beat release only.
  - Unchanged when both happen in the same cycle.
- No bypass at full: when occ == 2, s_ready_o stays 0 for that whole cycle, even if the final beat is released in that cycle. Space becomes visible on the next cycle.
- m_data_o is forced to 0 whenever m_valid_o == 0.
- flush_i (priority over all handshakes in its cycle):
  - Next state: occ=0, wr_ptr=0, rd_ptr=0, beat_idx=0.
  - Any s or m handshake in the flush cycle is discarded.
  - tile_cnt is not incremented and not cleared.
  - Slot contents need not be cleared.
- Reset:
  - Clears occ, wr_ptr, rd_ptr, beat_idx and tile_cnt.
  - Slot storage need not be reset.

## Timing
- Reset values of outputs: s_ready_o=1, m_valid_o=0, m_tfirst_o=0, m_tlast_o=0, m_data_o=0, tile_cnt_o=0. These hold throughout reset assertion.
- Reset asserted mid-tile: the partial tile is dropped at once and outputs take their reset values asynchronously.
- Latency: a tile accepted in cycle T with occ==0 presents beat 0 with m_valid_o=1 in cycle T+1.
- Throughput: with m_ready_i held high, one beat per cycle. Consecutive tiles continue without bubbles, so tile N+1's tfirst beat follows tile N's tlast beat in the next cycle when slot N+1 is already filled.
- Stability: while m_valid_o=1 and m_ready_i=0, m_data_o, m_tfirst_o and m_tlast_o hold stable. m_valid_o never deasserts without a handshake, except on flush or reset.
- tile_cnt_o updates in the cycle after the tlast handshake.

## Test plan
- Basic framing (MAT_SIZE=4, LANES_NUM=4, element e = e+1). Push one tile with m_ready_i=1.
  - Expect 4 beats in cycles T+1..T+4; beat0 lanes = 1,2,3,4 with tfirst=1; beat3 lanes = 13..16 with tlast=1.
  - Afterwards tile_cnt_o=1 and m_valid_o=0.
- Padding (MAT_SIZE=3, LANES_NUM=4). Push one tile.
  - Expect 3 beats; beat2 lane0 = element 8, lanes 1–3 = 0, with tlast on beat2.
- Backpressure and full (MAT_SIZE=4, LANES_NUM=4). Hold m_ready_i=0, push 3 tiles.
  - Expect 2 accepted; s_ready_o=0 after the second accept; beat 0 of tile A held stable.
  - Release m_ready_i: after A's tlast handshake, s_ready_o=1 in the next cycle and the third tile is accepted.
  - Expect tile B's tfirst in the cycle immediately after A's tlast.
- Simultaneous accept and release with occ=1: an accept and a final-beat handshake in the same cycle.
  - Expect occ stays 1 and m_valid_o stays 1.
  - Expect the next beat to be tfirst of the new tile.
- Flush mid-tile: assert flush_i during beat 2 of a tile while s_valid_i=1.
  - Next cycle: m_valid_o=0, s_ready_o=1, tile_cnt_o unchanged, and the concurrent input tile is not stored.
- Reset mid-operation: assert rst asynchronously with occ=2 and beat_idx=1.
  - Outputs take reset values immediately and tile_cnt_o=0.
  - A tile pushed after deassertion emits beat 0 with tfirst=1.

Source files
------------

// File: rtl/acc_tile_beatizer_if.sv
// acc_tile_beatizer_if
// Tile-in / beat-out handshake bundle for acc_tile_beatizer.
//   s_valid_i/s_ready_o/s_data_i : one full MAT_SIZE x MAT_SIZE tile per handshake
//   m_valid_o/m_ready_i/m_data_o : lane-wide output beats
//   m_tfirst_o/m_tlast_o         : first / last beat of a tile
// slave modport is the beatizer side, master modport the driving side.
interface acc_tile_beatizer_if #(
    parameter int MAT_SIZE  = 16,
    parameter int FP_DATA_W = 32,
    parameter int LANES_NUM = 16
);
    localparam int ELEMS = MAT_SIZE * MAT_SIZE;

    logic                           s_valid_i;
    logic                           s_ready_o;
    logic [ELEMS*FP_DATA_W-1:0]     s_data_i;
    logic                           m_valid_o;
    logic                           m_ready_i;
    logic [LANES_NUM*FP_DATA_W-1:0] m_data_o;
    logic                           m_tfirst_o;
    logic                           m_tlast_o;

    modport slave (
        input  s_valid_i, s_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o, m_tfirst_o, m_tlast_o
    );

    modport master (
        output s_valid_i, s_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o, m_tfirst_o, m_tlast_o
    );
endinterface

// File: rtl/acc_tile_beatizer.sv
// acc_tile_beatizer
// Double-buffered tile-to-beat converter. Accepts whole accumulator tiles and
// re-emits each as BEATS = ceil(ELEMS/LANES_NUM) beats with first/last markers.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush_i    : synchronous drop of all buffered tiles
//   bus        : acc_tile_beatizer_if.slave (tile input, beat output)
//   tile_cnt_o : number of tiles fully emitted (wraps at 16 bits)
module acc_tile_beatizer #(
    parameter int MAT_SIZE  = 16,
    parameter int FP_DATA_W = 32,
    parameter int LANES_NUM = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    acc_tile_beatizer_if.slave  bus,
    output logic [15:0]         tile_cnt_o
);
    localparam int ELEMS  = MAT_SIZE * MAT_SIZE;
    localparam int BEATS  = (ELEMS + LANES_NUM - 1) / LANES_NUM;
    localparam int BW     = $clog2(BEATS) + 1;
    localparam int IW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PADE   = BEATS * LANES_NUM;
    localparam int BEAT_W = LANES_NUM * FP_DATA_W;

    logic [ELEMS-1:0][FP_DATA_W-1:0] slot_q [2];
    logic                            wr_ptr_q, wr_ptr_d;
    logic                            rd_ptr_q, rd_ptr_d;
    logic [1:0]                      occ_q, occ_d;
    logic [BW-1:0]                   beat_q, beat_d;
    logic [15:0]                     cnt_q, cnt_d;

    logic s_acc, m_fire, last_beat, rel;

    assign bus.s_ready_o = (occ_q != 2'd2);
    assign bus.m_valid_o = (occ_q != 2'd0);
    assign last_beat     = (beat_q == BW'(BEATS - 1));
    assign s_acc         = bus.s_valid_i & bus.s_ready_o;
    assign m_fire        = bus.m_valid_o & bus.m_ready_i;
    assign rel           = m_fire & last_beat;

    assign bus.m_tfirst_o = bus.m_valid_o & (beat_q == '0);
    assign bus.m_tlast_o  = bus.m_valid_o & last_beat;
    assign tile_cnt_o     = cnt_q;

    // Read tile padded with zero elements up to a whole number of beats, then
    // viewed as an array of beats so the current beat is a single index.
    logic [ELEMS-1:0][FP_DATA_W-1:0] rd_tile;
    logic [PADE-1:0][FP_DATA_W-1:0]  pad;
    logic [BEATS-1:0][BEAT_W-1:0]    beats;

    assign rd_tile = slot_q[rd_ptr_q];

    for (genvar e = 0; e < PADE; e++) begin : g_pad
        if (e < ELEMS) begin : g_elem
            assign pad[e] = rd_tile[e];
        end else begin : g_zero
            assign pad[e] = '0;
        end
    end

    assign beats        = pad;
    assign bus.m_data_o = bus.m_valid_o ? beats[beat_q[IW-1:0]] : '0;

    // Slot storage carries no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (s_acc && !flush_i) slot_q[wr_ptr_q] <= bus.s_data_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        beat_d   = beat_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
            beat_d   = '0;
        end else begin
            if (s_acc) wr_ptr_d = ~wr_ptr_q;
            if (m_fire) begin
                if (last_beat) begin
                    beat_d   = '0;
                    rd_ptr_d = ~rd_ptr_q;
                    cnt_d    = cnt_q + 16'd1;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            // Accept and release in one cycle cancel out.
            case ({s_acc, rel})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            beat_q   <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            beat_q   <= beat_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_acc_tile_beatizer.sv
module tb_acc_tile_beatizer;
    typedef logic [15:0][31:0] tile_t;
    typedef struct {
        logic [127:0] d;
        logic         f;
        logic         l;
    } beat_t;

    logic clk, rst, flush, pflush;
    logic [15:0] tcnt, ptcnt;
    int tests = 0, fails = 0;
    beat_t sb[$];

    acc_tile_beatizer_if #(.MAT_SIZE(4), .FP_DATA_W(32), .LANES_NUM(4)) mif();
    acc_tile_beatizer_if #(.MAT_SIZE(3), .FP_DATA_W(32), .LANES_NUM(4)) pif();

    acc_tile_beatizer #(.MAT_SIZE(4), .FP_DATA_W(32), .LANES_NUM(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .bus(mif.slave), .tile_cnt_o(tcnt));
    acc_tile_beatizer #(.MAT_SIZE(3), .FP_DATA_W(32), .LANES_NUM(4)) pdut (
        .clk(clk), .rst(rst), .flush_i(pflush), .bus(pif.slave), .tile_cnt_o(ptcnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $error("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic tile_t mk_tile(input int base);
        tile_t t;
        for (int e = 0; e < 16; e++) t[e] = 32'(base + e + 1);
        return t;
    endfunction

    function automatic logic [127:0] exp_beat(input tile_t t, input int n, input int b);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < 4; l++)
            if (b * 4 + l < n) r[l*32 +: 32] = t[b*4+l];
        return r;
    endfunction

    task automatic push_exp(input tile_t t);
        beat_t bt;
        for (int b = 0; b < 4; b++) begin
            bt.d = exp_beat(t, 16, b);
            bt.f = (b == 0);
            bt.l = (b == 3);
            sb.push_back(bt);
        end
    endtask

    // Main-DUT scoreboard: every output handshake pops one expected beat.
    always @(negedge clk) begin
        if (!rst && !flush && mif.m_valid_o && mif.m_ready_i) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL sb_empty observed=beat expected=none");
            end
            if (sb.size() != 0) begin
                beat_t e;
                e = sb.pop_front();
                chk("sb_data", mif.m_data_o, e.d);
                chk("sb_tfirst", mif.m_tfirst_o, e.f);
                chk("sb_tlast", mif.m_tlast_o, e.l);
            end
        end
    end

    task automatic push(input tile_t t);
        logic got;
        got = 1'b0;
        mif.s_data_i  = t;
        mif.s_valid_i = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (mif.s_ready_o) begin
                got = 1'b1;
                push_exp(t);
            end
        end
        chk("push_accepted", got, 1'b1);
        @(posedge clk); #1;
        mif.s_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 128'(sb.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        tile_t a, bt, ct, dt, ft, gt, ht, pt;
        logic [15:0] c0;
        logic found;
        rst = 1'b1; flush = 1'b0; pflush = 1'b0;
        mif.s_valid_i = 1'b0; mif.s_data_i = '0; mif.m_ready_i = 1'b0;
        pif.s_valid_i = 1'b0; pif.s_data_i = '0; pif.m_ready_i = 1'b1;

        // Reset values held while reset is asserted.
        repeat (2) @(negedge clk);
        chk("rst_s_ready", mif.s_ready_o, 1'b1);
        chk("rst_m_valid", mif.m_valid_o, 1'b0);
        chk("rst_tfirst", mif.m_tfirst_o, 1'b0);
        chk("rst_tlast", mif.m_tlast_o, 1'b0);
        chk("rst_data", mif.m_data_o, '0);
        chk("rst_tile_cnt", tcnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Padding: 9 elements over 3 beats of 4 lanes.
        pt = mk_tile(0);
        pif.s_data_i  = pt[8:0];
        pif.s_valid_i = 1'b1;
        @(negedge clk);
        chk("pad_s_ready", pif.s_ready_o, 1'b1);
        @(posedge clk); #1;
        pif.s_valid_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            chk("pad_valid", pif.m_valid_o, 1'b1);
            chk("pad_data", pif.m_data_o, exp_beat(pt, 9, b));
            chk("pad_tfirst", pif.m_tfirst_o, b == 0);
            chk("pad_tlast", pif.m_tlast_o, b == 2);
        end
        @(negedge clk);
        chk("pad_idle", pif.m_valid_o, 1'b0);
        chk("pad_cnt", ptcnt, 1);
        @(posedge clk); #1;

        // Basic framing with latency check.
        mif.m_ready_i = 1'b1;
        a = mk_tile(0);
        push(a);
        @(negedge clk);
        chk("lat_valid", mif.m_valid_o, 1'b1);
        chk("lat_tfirst", mif.m_tfirst_o, 1'b1);
        chk("lat_beat0", mif.m_data_o, {32'd4, 32'd3, 32'd2, 32'd1});
        repeat (4) @(posedge clk); #1;
        chk("basic_cnt", tcnt, 1);
        chk("basic_idle", mif.m_valid_o, 1'b0);
        chk("basic_sb", 128'(sb.size()), 0);

        // Backpressure and full.
        mif.m_ready_i = 1'b0;
        bt = mk_tile(100); ct = mk_tile(200); dt = mk_tile(300);
        push(bt);
        push(ct);
        mif.s_data_i  = dt;
        mif.s_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_s_ready", mif.s_ready_o, 1'b0);
            chk("hold_data", mif.m_data_o, exp_beat(bt, 16, 0));
            chk("hold_tfirst", mif.m_tfirst_o, 1'b1);
        end
        @(posedge clk); #1;
        mif.m_ready_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mif.m_tlast_o) begin
                found = 1'b1;
                chk("no_bypass", mif.s_ready_o, 1'b0);
            end
        end
        chk("b_tlast_seen", found, 1'b1);
        @(negedge clk);
        chk("c_tfirst_next", mif.m_tfirst_o, 1'b1);
        chk("c_valid", mif.m_valid_o, 1'b1);
        chk("space_visible", mif.s_ready_o, 1'b1);
        push_exp(dt);
        @(posedge clk); #1;
        mif.s_valid_i = 1'b0;
        drain();
        chk("bp_cnt", tcnt, 4);

        // Simultaneous accept and final-beat release at occ=1.
        push(mk_tile(400));
        ft = mk_tile(500);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mif.m_tlast_o) found = 1'b1;
        end
        chk("e_tlast_seen", found, 1'b1);
        chk("sim_s_ready", mif.s_ready_o, 1'b1);
        mif.s_data_i  = ft;
        mif.s_valid_i = 1'b1;
        push_exp(ft);
        @(posedge clk); #1;
        mif.s_valid_i = 1'b0;
        @(negedge clk);
        chk("sim_valid", mif.m_valid_o, 1'b1);
        chk("sim_tfirst", mif.m_tfirst_o, 1'b1);
        chk("sim_occ1", mif.s_ready_o, 1'b1);
        drain();
        chk("sim_cnt", tcnt, 6);

        // Flush during beat 2 with a concurrent input tile.
        gt = mk_tile(600); ht = mk_tile(700);
        push(gt);
        @(posedge clk); #1;
        @(posedge clk); #1;
        c0 = tcnt;
        flush = 1'b1;
        mif.s_data_i  = ht;
        mif.s_valid_i = 1'b1;
        @(negedge clk);
        chk("fl_beat2", mif.m_data_o, exp_beat(gt, 16, 2));
        @(posedge clk); #1;
        flush = 1'b0;
        mif.s_valid_i = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("fl_valid", mif.m_valid_o, 1'b0);
        chk("fl_s_ready", mif.s_ready_o, 1'b1);
        chk("fl_cnt", tcnt, c0);
        @(posedge clk); #1;
        push(mk_tile(800));
        drain();
        chk("fl_cnt_after", tcnt, c0 + 16'd1);

        // Asynchronous reset with occ=2 and beat_idx=1.
        mif.m_ready_i = 1'b0;
        push(mk_tile(900));
        push(mk_tile(1000));
        mif.m_ready_i = 1'b1;
        @(posedge clk); #1;
        mif.m_ready_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_beat1", mif.m_data_o, exp_beat(mk_tile(900), 16, 1));
        chk("pre_rst_full", mif.s_ready_o, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", mif.m_valid_o, 1'b0);
        chk("arst_s_ready", mif.s_ready_o, 1'b1);
        chk("arst_data", mif.m_data_o, '0);
        chk("arst_tfirst", mif.m_tfirst_o, 1'b0);
        chk("arst_tlast", mif.m_tlast_o, 1'b0);
        chk("arst_cnt", tcnt, 0);
        sb.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        mif.m_ready_i = 1'b1;
        push(mk_tile(1100));
        @(negedge clk);
        chk("post_rst_tfirst", mif.m_tfirst_o, 1'b1);
        drain();
        chk("post_rst_cnt", tcnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
